// File: rtl/uart_byte_tx.sv
// uart_byte_tx
// Byte-wide 8N1 UART transmitter (LSB first) with a valid/ready input handshake.
// Sends each byte taken from the upstream read-out stage on a single TX pin.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (2..65535); 434 gives 115200 baud at 50 MHz
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   in_data      byte to transmit, sampled only on the transfer edge
//   in_valid     in_data is valid this cycle
//   in_ready     block can accept a byte this cycle (IDLE and not in reset)
//   tx           serial line, idle high (registered)
//   busy         a frame is in progress (registered)
//   frame_count  frames completed since reset, wraps at 16 bits
//
// State table:
//   state | meaning
//   IDLE  | line high, waiting for a byte
//   START | driving the start bit (low)
//   DATA  | shifting out the 8 data bits, LSB first
//   STOP  | driving STOP_BITS stop bits (high)

module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [0:0]  stop_cnt;
    logic [15:0] baud_cnt;
    logic        bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign in_ready = (state == IDLE) && !reset;

    // tx and busy are loaded with the value belonging to the state being
    // entered, so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= 8'h00;
            bit_cnt     <= 3'd0;
            stop_cnt    <= 1'b0;
            baud_cnt    <= 16'd0;
            frame_count <= 16'd0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift    <= in_data;
                        baud_cnt <= 16'd0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        shift    <= shift >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            // next bit is shift[1] before the shift takes effect
                            tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (stop_cnt == STOP_LAST) begin
                            state       <= IDLE;
                            frame_count <= frame_count + 16'd1;
                            busy        <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx: three instances with different bit timing.
//   a: CLKS_PER_BIT=4, STOP_BITS=1  (reset, abort, table of bytes, stall)
//   b: CLKS_PER_BIT=3, STOP_BITS=2  (two stop bits)
//   c: CLKS_PER_BIT=2, STOP_BITS=1  (frame_count wrap)

module tb_uart_byte_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_in_valid, a_in_ready, a_tx, a_busy;
    logic [7:0]  a_in_data;
    logic [15:0] a_frame_count;
    logic        b_reset, b_in_valid, b_in_ready, b_tx, b_busy;
    logic [7:0]  b_in_data;
    logic [15:0] b_frame_count;
    logic        c_reset, c_in_valid, c_in_ready, c_tx, c_busy;
    logic [7:0]  c_in_data;
    logic [15:0] c_frame_count;

    uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .tx(a_tx), .busy(a_busy), .frame_count(a_frame_count)
    );

    uart_byte_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .tx(b_tx), .busy(b_busy), .frame_count(b_frame_count)
    );

    uart_byte_tx #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_c (
        .clk(clk), .reset(c_reset), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .tx(c_tx), .busy(c_busy), .frame_count(c_frame_count)
    );

    // slots: bit s is the line level during slot s (start, d0..d7, stop)
    typedef struct {
        logic [7:0]  data;
        logic [9:0]  slots;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents the byte and returns in the
    // cycle after the transfer edge with in_valid still high.
    task automatic start_a(input logic [7:0] d, input string tag);
        int w;
        w = 0;
        while (!a_in_ready && w < 100) begin
            tick();
            w++;
        end
        check($sformatf("%s_ready", tag), 64'(a_in_ready), 64'd1);
        a_in_valid = 1'b1;
        a_in_data  = d;
        tick();
    endtask

    // Watches one 40-cycle frame on instance a starting in the cycle after
    // the transfer edge, then checks the idle cycle that follows.
    task automatic watch_a(input logic [9:0] slots, input string tag);
        logic [39:0] obs;
        int busy_n, rdy_n;
        busy_n = 0;
        rdy_n  = 0;
        obs    = '0;
        for (int i = 0; i < 40; i++) begin
            obs[i] = a_tx;
            busy_n += int'(a_busy);
            rdy_n  += int'(a_in_ready);
            tick();
        end
        for (int s = 0; s < 10; s++)
            check($sformatf("%s_slot%0d", tag, s), 64'(obs[s*4 +: 4]), 64'({4{slots[s]}}));
        check($sformatf("%s_busy_cycles", tag), 64'(busy_n), 64'd40);
        check($sformatf("%s_ready_in_frame", tag), 64'(rdy_n), 64'd0);
        check($sformatf("%s_idle_tx", tag), 64'(a_tx), 64'd1);
        check($sformatf("%s_idle_busy", tag), 64'(a_busy), 64'd0);
        check($sformatf("%s_idle_ready", tag), 64'(a_in_ready), 64'd1);
    endtask

    initial begin
        logic [32:0] obs_b;
        int busy_b, falls;
        logic prev_busy;

        vecs[0] = '{data: 8'h55, slots: 10'b1010101010, fc: 16'd1};
        vecs[1] = '{data: 8'hA5, slots: 10'b1101001010, fc: 16'd2};
        vecs[2] = '{data: 8'h01, slots: 10'b1000000010, fc: 16'd3};
        vecs[3] = '{data: 8'h80, slots: 10'b1100000000, fc: 16'd4};

        a_reset = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hA5;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00;
        c_reset = 1'b1; c_in_valid = 1'b0; c_in_data = 8'h00;

        // reset held two cycles with in_valid high: nothing starts
        tick();
        tick();
        check("rst_tx", 64'(a_tx), 64'd1);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_ready", 64'(a_in_ready), 64'd0);
        check("rst_fc", 64'(a_frame_count), 64'd0);
        check("rst_b_tx", 64'(b_tx), 64'd1);
        a_in_valid = 1'b0;
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        tick();
        check("rst_after_busy", 64'(a_busy), 64'd0);
        check("rst_after_ready", 64'(a_in_ready), 64'd1);

        // reset during data bit 3 of 0x81 aborts the frame
        start_a(8'h81, "abort");
        a_in_valid = 1'b0;
        check("abort_start_bit", 64'(a_tx), 64'd0);
        for (int i = 0; i < 17; i++) tick();
        check("abort_bit3", 64'(a_tx), 64'd0);
        a_reset = 1'b1;
        tick();
        check("abort_tx", 64'(a_tx), 64'd1);
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_fc", 64'(a_frame_count), 64'd0);
        check("abort_ready_in_rst", 64'(a_in_ready), 64'd0);
        a_reset = 1'b0;
        #1;
        check("abort_ready_after", 64'(a_in_ready), 64'd1);

        // table of single bytes; the first one transfers on the first edge after reset
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_a(vecs[i].data, tag);
            a_in_valid = 1'b0;
            watch_a(vecs[i].slots, tag);
            check($sformatf("%s_fc", tag), 64'(a_frame_count), 64'(vecs[i].fc));
        end

        // stall: in_valid stays high, data changes mid-frame
        start_a(8'h3C, "stall_3c");
        a_in_data = 8'hFF;
        watch_a(10'b1001111000, "stall_3c");
        tick();
        a_in_valid = 1'b0;
        watch_a(10'b1111111110, "stall_ff");
        check("stall_fc", 64'(a_frame_count), 64'd6);

        // two stop bits, 3 clocks per bit, byte 0x00
        check("b_ready", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h00;
        tick();
        b_in_valid = 1'b0;
        obs_b  = '0;
        busy_b = 0;
        for (int i = 0; i < 33; i++) begin
            obs_b[i] = b_tx;
            busy_b += int'(b_busy);
            tick();
        end
        check("b_frame_tx", 64'(obs_b), 64'({6'b111111, 27'd0}));
        check("b_busy_cycles", 64'(busy_b), 64'd33);
        check("b_idle_busy", 64'(b_busy), 64'd0);
        check("b_idle_tx", 64'(b_tx), 64'd1);
        check("b_fc", 64'(b_frame_count), 64'd1);

        // frame_count wrap: back-to-back frames counted by busy falling edges
        c_in_valid = 1'b1;
        c_in_data  = 8'h5A;
        falls      = 0;
        prev_busy  = c_busy;
        for (int cyc = 0; cyc < 1400000 && falls < 65537; cyc++) begin
            tick();
            if (prev_busy && !c_busy) begin
                falls++;
                if (falls == 65535) check("wrap_ffff", 64'(c_frame_count), 64'hFFFF);
                if (falls == 65536) check("wrap_0000", 64'(c_frame_count), 64'h0000);
                if (falls == 65537) check("wrap_0001", 64'(c_frame_count), 64'h0001);
            end
            prev_busy = c_busy;
        end
        check("wrap_frames_seen", 64'(falls), 64'd65537);
        c_in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
